iterative_shifter: RTL and testbench

- Multi-cycle shift unit between the ALU operand/decode stage (upstream) and the register writeback mux (downstream).
- Performs SLL, SRL and SRA by chaining the fixed-amount power-of-two shift primitives, one stage per cycle. Each stage shifts by 2^k when bit k of the shift amount is set.
- Uses a valid/ready handshake on both sides so the control unit can stall around it.

---
 rtl/iterative_shifter_if.sv | 42 ++++
 rtl/iterative_shifter.sv | 169 ++++++++++++++++
 tb/tb_iterative_shifter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/iterative_shifter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iterative_shifter_if                                          |
// | Purpose  : Handshake bundle for the iterative shifter. Carries the       |
// |            upstream request channel (valid/ready, operand, shift        |
// |            amount, opcode), the downstream result channel               |
// |            (valid/ready, result) and the busy status flag.              |
// | Ports    : valid_i, value_i, shamt_i, op_i  - request from upstream      |
// |            ready_o                          - unit can accept request   |
// |            valid_o, value_o                 - result to downstream      |
// |            ready_i                          - downstream accepts result |
// |            busy_o                           - operation in flight       |
// |            Suffixes name the direction as seen by the shifter.          |
// | Modports : master (control unit side), slave (shifter side)             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface iterative_shifter_if #(
  parameter int XLEN = 32
);
  localparam int SHW = $clog2(XLEN);

  logic            valid_i;
  logic            ready_o;
  logic [XLEN-1:0] value_i;
  logic [SHW-1:0]  shamt_i;
  logic [1:0]      op_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] value_o;
  logic            busy_o;

  modport master (
    output valid_i, value_i, shamt_i, op_i, ready_i,
    input  ready_o, valid_o, value_o, busy_o
  );

  modport slave (
    input  valid_i, value_i, shamt_i, op_i, ready_i,
    output ready_o, valid_o, value_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/iterative_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iterative_shifter                                             |
// | Purpose  : Multi-cycle SLL / SRL / SRA unit. One fixed power-of-two      |
// |            shift stage is evaluated per cycle; stage k shifts by 2^k    |
// |            when bit k of the captured shift amount is set.              |
// | Ports    : clk_i  - clock, rising edge                                   |
// |            rst_i  - synchronous active-high reset                        |
// |            bus    - iterative_shifter_if.slave (request, result, busy)  |
// | Params   : XLEN   - data width, power of two, 8 or greater              |
// |            SHW    - derived, $clog2(XLEN): shamt width / stage count    |
// | Options  : ITERATIVE_SHIFTER_EARLY_EXIT_EN - when defined, the unit     |
// |            stops once no higher shift-amount bits remain set, so        |
// |            latency tracks the highest set bit of shamt. Results are     |
// |            identical with or without it.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module iterative_shifter #(
  parameter int XLEN = 32
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  iterative_shifter_if.slave   bus
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] data_q,  data_d;
  logic [SHW-1:0]  shamt_q, shamt_d;
  logic [1:0]      op_q,    op_d;
  logic [SHW-1:0]  k_q,     k_d;

  logic            ready_w;
  logic            valid_w;
  logic            busy_w;
  logic [XLEN-1:0] stage_w;

  // Fixed-amount shift primitives, one per stage. The arithmetic variant
  // fills with data_q's MSB: an arithmetic shift never changes the MSB, so
  // it still equals the original operand's sign bit at every stage.
  logic [XLEN-1:0] sll_stage [SHW];
  logic [XLEN-1:0] srl_stage [SHW];
  logic [XLEN-1:0] sra_stage [SHW];

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    localparam int AMT = 1 << g;
    assign sll_stage[g] = {data_q[XLEN-1-AMT:0], {AMT{1'b0}}};
    assign srl_stage[g] = {{AMT{1'b0}}, data_q[XLEN-1:AMT]};
    assign sra_stage[g] = {{AMT{data_q[XLEN-1]}}, data_q[XLEN-1:AMT]};
  end

  // Result of the stage selected by the current counter, before the
  // shamt bit decides whether it is applied.
  always_comb begin
    stage_w = data_q;
    case (op_q)
      OP_SLL:  stage_w = sll_stage[k_q];
      OP_SRL:  stage_w = srl_stage[k_q];
      OP_SRA:  stage_w = sra_stage[k_q];
      default: stage_w = data_q;
    endcase
  end

`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
  // High when every shamt bit above the current stage is clear, i.e. the
  // stage being applied now is the last one with any effect.
  logic upper_zero_w;
  assign upper_zero_w = ((shamt_q >> k_q) >> 1) == '0;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    k_d     = k_q;
    ready_w = 1'b0;
    valid_w = 1'b0;
    busy_w  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_w = 1'b1;
        if (bus.valid_i) begin
          data_d  = bus.value_i;
          shamt_d = bus.shamt_i;
          op_d    = bus.op_i;
          k_d     = '0;
`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
          if (bus.op_i == OP_PASS || bus.shamt_i == '0) begin
`else
          if (bus.op_i == OP_PASS) begin
`endif
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        busy_w = 1'b1;
        if (shamt_q[k_q]) begin
          data_d = stage_w;
        end
        k_d = k_q + SHW'(1);
`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
        if (k_q == K_LAST || upper_zero_w) begin
`else
        if (k_q == K_LAST) begin
`endif
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_w  = 1'b1;
        valid_w = 1'b1;
        // Returning to IDLE does not also accept a request on this edge.
        if (bus.ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      k_q     <= k_d;
    end
  end

  assign bus.ready_o = ready_w;
  assign bus.valid_o = valid_w;
  assign bus.busy_o  = busy_w;
  // Result comes straight from the data register, so it stays stable under
  // backpressure and keeps the last result while idle.
  assign bus.value_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_iterative_shifter                                          |
// | Purpose  : Self-checking bench for iterative_shifter (XLEN=32). Vector   |
// |            table of operations with hand-computed results plus directed |
// |            sequences for reset, backpressure and reset mid-operation.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_iterative_shifter;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  iterative_shifter_if #(.XLEN(XLEN)) bus ();

  iterative_shifter #(.XLEN(XLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] value;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] expected;
  } vec_t;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Edges after the accept edge until valid_o rises.
  function automatic int exp_lat(input logic [1:0] op, input logic [SHW-1:0] sh);
    if (op == 2'b11) return 0;
`ifdef ITERATIVE_SHIFTER_EARLY_EXIT_EN
    for (int i = SHW - 1; i >= 0; i--) begin
      if (sh[i]) return i + 1;
    end
    return 0;
`else
    return SHW;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for valid_o; checks latency, result and
  // ready_o low while the unit is working. Leaves the unit in DONE.
  task automatic issue(input string name, input logic [1:0] op,
                       input logic [XLEN-1:0] value, input logic [SHW-1:0] sh,
                       input logic [XLEN-1:0] expected);
    int cycles;
    chk({name, " ready_before"}, {31'd0, bus.ready_o}, 32'd1);
    bus.valid_i = 1'b1;
    bus.value_i = value;
    bus.shamt_i = sh;
    bus.op_i    = op;
    tick();
    bus.valid_i = 1'b0;
    bus.value_i = 32'hA5A5_5A5A;
    cycles = 0;
    while (!bus.valid_o && cycles < 20) begin
      if (bus.ready_o) begin
        checks++;
        failures++;
        $display("FAIL %s ready_busy: got ready_o=1 expected 0 at cycle %0d", name, cycles);
      end
      tick();
      cycles++;
    end
    chk({name, " latency"}, 32'(cycles), 32'(exp_lat(op, sh)));
    chk({name, " value"}, bus.value_o, expected);
    chk({name, " ready_done"}, {31'd0, bus.ready_o}, 32'd0);
  endtask

  task automatic release_result(input string name, input logic [XLEN-1:0] expected);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk({name, " valid_after"}, {31'd0, bus.valid_o}, 32'd0);
    chk({name, " ready_after"}, {31'd0, bus.ready_o}, 32'd1);
    chk({name, " busy_after"},  {31'd0, bus.busy_o},  32'd0);
    chk({name, " value_kept"},  bus.value_o, expected);
  endtask

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[2]  = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
    vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
    vecs[6]  = '{2'b10, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
    vecs[7]  = '{2'b10, 32'h8000_0001, 5'd1,  32'hC000_0000};
    vecs[8]  = '{2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678};
    vecs[9]  = '{2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780};
    vecs[10] = '{2'b01, 32'h1234_5678, 5'd16, 32'h0000_1234};
    vecs[11] = '{2'b10, 32'h8000_0000, 5'd3,  32'hF000_0000};
    vecs[12] = '{2'b00, 32'h0000_00FF, 5'd10, 32'h0003_FC00};

    bus.valid_i = 1'b0;
    bus.value_i = '0;
    bus.shamt_i = '0;
    bus.op_i    = 2'b00;
    bus.ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("reset ready_o", {31'd0, bus.ready_o}, 32'd1);
    chk("reset valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("reset busy_o",  {31'd0, bus.busy_o},  32'd0);
    chk("reset value_o", bus.value_o, 32'h0);
    tick();
    chk("idle stays", {31'd0, bus.ready_o}, 32'd1);

    // Backpressure: SLL 0xF by 8, hold ready_i low with valid_i pulses.
    issue("bp", 2'b00, 32'h0000_000F, 5'd8, 32'h0000_0F00);
    for (int i = 0; i < 3; i++) begin
      bus.valid_i = (i != 1);
      bus.value_i = 32'hFFFF_0000 + 32'(i);
      bus.op_i    = 2'b11;
      tick();
      chk("bp hold valid", {31'd0, bus.valid_o}, 32'd1);
      chk("bp hold value", bus.value_o, 32'h0000_0F00);
    end
    // Request still present on the release edge must not be accepted.
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("bp release valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("bp release ready_o", {31'd0, bus.ready_o}, 32'd1);
    chk("bp release busy_o",  {31'd0, bus.busy_o},  32'd0);
    chk("bp release value_o", bus.value_o, 32'h0000_0F00);
    tick();
    chk("bp no accept", {31'd0, bus.ready_o}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].value, vecs[i].shamt,
            vecs[i].expected);
      release_result($sformatf("vec%0d", i), vecs[i].expected);
    end

    // Reset mid-operation at stage k=2 of an SLL by 31.
    bus.valid_i = 1'b1;
    bus.value_i = 32'h0000_0001;
    bus.shamt_i = 5'd31;
    bus.op_i    = 2'b00;
    tick();
    bus.valid_i = 1'b0;
    tick();
    tick();
    chk("midrst busy", {31'd0, bus.busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst ready_o", {31'd0, bus.ready_o}, 32'd1);
    chk("midrst valid_o", {31'd0, bus.valid_o}, 32'd0);
    chk("midrst value_o", bus.value_o, 32'h0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.valid_o || bus.busy_o) seen++;
    end
    chk("midrst no result", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
